// File: rtl/tcpdump_pkg.sv
// tcpdump_pkg: shared state type, word size and burst sizing rule for the capture read path
package tcpdump_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} rd_state_t;
  localparam int WORD_BYTES = 4;
  function automatic logic [31:0] burst_len(input logic [31:0] remaining, input logic [31:0] max, input logic single);
    return single ? 32'd1 : (remaining < max ? remaining : max);
  endfunction
endpackage

// File: rtl/rd_ctrl_if.sv
// rd_ctrl_if: control, Avalon-MM read and FIFO write signals of the packet read controller
interface rd_ctrl_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int BURST_W = 16
);
  logic               rd_ctrl, almost_full, rd_ctrl_rdy, fifo_wr;
  logic               read, waitrequest, readdatavalid;
  logic [31:0]        control;
  logic [ADDR_W-1:0]  pkt_begin, pkt_end, address;
  logic [DATA_W-1:0]  fifo_in, readdata;
  logic [BURST_W-1:0] burstcount;
  modport master (
    input  rd_ctrl, almost_full, control, pkt_begin, pkt_end, waitrequest, readdata, readdatavalid,
    output rd_ctrl_rdy, fifo_in, fifo_wr, address, read, burstcount
  );
  modport slave (
    output rd_ctrl, almost_full, control, pkt_begin, pkt_end, waitrequest, readdata, readdatavalid,
    input  rd_ctrl_rdy, fifo_in, fifo_wr, address, read, burstcount
  );
endinterface

// File: rtl/rd_ctrl.sv
// rd_ctrl: Avalon-MM burst read master pushing one packet into the output FIFO; RD_CTRL_BSWAP_EN byte-reverses each word
module rd_ctrl
  import tcpdump_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 8,
  parameter int BURST_W   = 16
) (
  input logic        clk,
  input logic        reset,
  rd_ctrl_if.master  bus
);
  rd_state_t          state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d, rem_q, rem_d, words;
  logic [ADDR_W:0]    span;
  logic [BURST_W-1:0] bc_q, bc_d, beats_q, beats_d;
  logic               read_q, read_d, wr_q, wr_d, rdy_q, rdy_d;
  logic [DATA_W-1:0]  dat_q, dat_d, rd_word;

  assign span  = {1'b0, bus.pkt_end} - {1'b0, bus.pkt_begin} + (ADDR_W+1)'(3);
  assign words = (bus.pkt_end < bus.pkt_begin) ? '0 : ADDR_W'(span >> 2);

`ifdef RD_CTRL_BSWAP_EN
  assign rd_word = {<<8{bus.readdata}};
`else
  assign rd_word = bus.readdata;
`endif

  assign bus.address     = addr_q;
  assign bus.read        = read_q;
  assign bus.burstcount  = bc_q;
  assign bus.fifo_in     = dat_q;
  assign bus.fifo_wr     = wr_q;
  assign bus.rd_ctrl_rdy = rdy_q;

  // state and output registers; reset aborts any burst in flight
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      bc_q    <= '0;
      beats_q <= '0;
      read_q  <= 1'b0;
      wr_q    <= 1'b0;
      rdy_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      bc_q    <= bc_d;
      beats_q <= beats_d;
      read_q  <= read_d;
      wr_q    <= wr_d;
      rdy_q   <= rdy_d;
      dat_q   <= dat_d;
    end

  // next state: latch the packet, issue bursts while the FIFO has room, count returning beats
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    bc_d    = bc_q;
    beats_d = beats_q;
    read_d  = read_q;
    wr_d    = 1'b0;
    dat_d   = dat_q;
    case (state_q)
      IDLE: if (bus.rd_ctrl) begin
        addr_d  = bus.pkt_begin;
        rem_d   = words;
        state_d = (words == '0) ? DONE : REQ;
      end
      REQ: if (read_q) begin
        if (!bus.waitrequest) begin
          read_d  = 1'b0;
          rem_d   = rem_q - ADDR_W'(bc_q);
          addr_d  = addr_q + ADDR_W'(bc_q) * ADDR_W'(WORD_BYTES);
          beats_d = bc_q;
          state_d = DATA;
        end
      end else if (!bus.almost_full) begin
        read_d = 1'b1;
        bc_d   = BURST_W'(burst_len(32'(rem_q), 32'(MAX_BURST), bus.control[0]));
      end
      DATA: if (bus.readdatavalid) begin
        wr_d    = 1'b1;
        dat_d   = rd_word;
        beats_d = beats_q - BURST_W'(1);
        if (beats_q == BURST_W'(1)) state_d = (rem_q == '0) ? DONE : REQ;
      end
      DONE: if (!bus.rd_ctrl) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == DONE);
  end
endmodule

// File: tb/tb_rd_ctrl.sv
// tb_rd_ctrl: randomized scoreboard bench for rd_ctrl with an Avalon slave model and a FIFO monitor
`timescale 1ns/1ps
module tb_rd_ctrl;
  localparam int DATA_W = 32, ADDR_W = 32, MAX_BURST = 8, BURST_W = 16;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  rd_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) bus ();
  rd_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST), .BURST_W(BURST_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int vectors = 0, miscompares = 0;
  logic [31:0] exp_q[$];
  logic [63:0] burst_q[$];
  logic [31:0] beat_q[$];
  int cyc = 0, beat_ready = 0, wait_left = 0, wait_pct = 0, gap_pct = 0, got = 0, accepts = 0;
  logic [31:0] salt = 32'd0;
  logic prev_read = 1'b0, prev_wait = 1'b0, af_edge = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [15:0] prev_bc = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return salt + (a >> 2);
  endfunction

  function automatic logic [31:0] to_fifo(input logic [31:0] w);
`ifdef RD_CTRL_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // reference model: expected words and burst list from the packet bounds, then start the read
  task automatic run_pkt(input logic [31:0] b, input logic [31:0] e, input logic single);
    longint n, rem, len;
    logic [31:0] a;
    @(negedge clk);
    #2;
    n = (e < b) ? 0 : (longint'(e) - longint'(b) + 3) / 4;
    for (longint i = 0; i < n; i++) exp_q.push_back(to_fifo(mem_word(b + 32'(i * 4))));
    rem = n;
    a = b;
    while (rem > 0) begin
      len = single ? 1 : (rem < MAX_BURST ? rem : MAX_BURST);
      burst_q.push_back({a, 32'(len)});
      a += 32'(len * 4);
      rem -= len;
    end
    got = 0;
    bus.pkt_begin = b;
    bus.pkt_end = e;
    bus.control = {31'b0, single};
    bus.rd_ctrl = 1'b1;
  endtask

  task automatic finish_pkt(input string tag, input int budget, input bit rnd_af, input bit drop);
    int t = 0;
    while (!bus.rd_ctrl_rdy && t < budget) begin
      @(negedge clk);
      #2;
      t++;
      if (rnd_af) bus.almost_full = ($urandom_range(0, 3) == 0);
      if (drop && t == 2) bus.rd_ctrl = 1'b0;
    end
    chk({tag, " rdy"}, 64'(bus.rd_ctrl_rdy), 64'd1);
    chk({tag, " words left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, " bursts left"}, 64'(burst_q.size()), 64'd0);
    bus.almost_full = 1'b0;
    bus.rd_ctrl = 1'b0;
    @(negedge clk);
    #2;
    chk({tag, " rdy clear"}, 64'(bus.rd_ctrl_rdy), 64'd0);
    exp_q.delete();
    burst_q.delete();
  endtask

  always @(posedge clk) af_edge <= bus.almost_full;

  // FIFO monitor: every write strobe pops one expected word
  initial forever begin
    @(negedge clk);
    if (bus.fifo_wr) begin
      if (exp_q.size() == 0) fail("unexpected fifo_wr");
      else begin
        chk("fifo_in", 64'(bus.fifo_in), 64'(exp_q.pop_front()));
        got++;
      end
    end
  end

  // Avalon slave model: waitrequest, burst checks, beats returned two cycles after grant
  initial begin
    logic [63:0] e;
    bus.waitrequest = 1'b0;
    bus.readdatavalid = 1'b0;
    bus.readdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset && prev_read && prev_wait) begin
        chk("read held", 64'(bus.read), 64'd1);
        chk("address held", 64'(bus.address), 64'(prev_addr));
        chk("burstcount held", 64'(bus.burstcount), 64'(prev_bc));
      end
      if (bus.read && !prev_read) chk("almost_full at issue", 64'(af_edge), 64'd0);
      if (bus.read && wait_left > 0) begin
        bus.waitrequest = 1'b1;
        wait_left--;
      end else bus.waitrequest = bus.read && ($urandom_range(0, 99) < wait_pct);
      if (bus.read && !bus.waitrequest) begin
        accepts++;
        if (burst_q.size() == 0) fail("unexpected burst");
        else begin
          e = burst_q.pop_front();
          chk("burst address", 64'(bus.address), 64'(e[63:32]));
          chk("burstcount", 64'(bus.burstcount), 64'(e[31:0]));
        end
        for (int k = 0; k < int'(bus.burstcount); k++) beat_q.push_back(mem_word(bus.address + 32'(4 * k)));
        beat_ready = cyc + 2;
      end
      if (beat_q.size() > 0 && cyc >= beat_ready && $urandom_range(0, 99) >= gap_pct) begin
        bus.readdatavalid = 1'b1;
        bus.readdata = beat_q.pop_front();
      end else begin
        bus.readdatavalid = (beat_q.size() == 0) && ($urandom_range(0, 9) == 0);
        bus.readdata = $urandom;
      end
      prev_read = bus.read;
      prev_wait = bus.waitrequest;
      prev_addr = bus.address;
      prev_bc = bus.burstcount;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int t, a0;
    logic [31:0] b, e;
    bus.rd_ctrl = 1'b0;
    bus.almost_full = 1'b0;
    bus.control = '0;
    bus.pkt_begin = '0;
    bus.pkt_end = '0;
    #1 reset = 1'b0;
    #1;
    chk("reset read", 64'(bus.read), 64'd0);
    chk("reset fifo_wr", 64'(bus.fifo_wr), 64'd0);
    chk("reset rdy", 64'(bus.rd_ctrl_rdy), 64'd0);
    chk("reset address", 64'(bus.address), 64'd0);
    chk("reset burstcount", 64'(bus.burstcount), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    salt = 32'd10;
    run_pkt(32'd0, 32'd32, 1'b0);
    finish_pkt("normal", 200, 0, 0);

    salt = $urandom;
    run_pkt(32'd0, 32'd80, 1'b0);
    finish_pkt("multi", 400, 0, 0);

    salt = $urandom;
    a0 = accepts;
    wait_left = 2;
    run_pkt(32'd0, 32'd80, 1'b0);
    t = 0;
    while (accepts == a0 && t < 50) begin @(negedge clk); #2; t++; end
    bus.almost_full = 1'b1;
    t = 0;
    while (got < 8 && t < 100) begin @(negedge clk); #2; t++; end
    chk("stall first burst words", 64'(got), 64'd8);
    repeat (3) begin
      @(negedge clk);
      #2;
      chk("stall read blocked", 64'(bus.read), 64'd0);
    end
    bus.almost_full = 1'b0;
    finish_pkt("stall", 400, 0, 0);

    run_pkt(32'h40, 32'h40, 1'b0);
    @(negedge clk);
    #2;
    chk("empty rdy next cycle", 64'(bus.rd_ctrl_rdy), 64'd1);
    chk("empty no read", 64'(bus.read), 64'd0);
    finish_pkt("empty", 10, 0, 0);

    salt = $urandom;
    run_pkt(32'd0, 32'd16, 1'b1);
    finish_pkt("single", 200, 0, 0);

    run_pkt(32'd100, 32'd40, 1'b0);
    finish_pkt("reversed", 10, 0, 0);

    salt = 32'h11223344;
    run_pkt(32'd0, 32'd4, 1'b0);
    finish_pkt("bswap word", 100, 0, 0);

    salt = $urandom;
    run_pkt(32'd0, 32'd32, 1'b0);
    t = 0;
    while (got < 3 && t < 100) begin @(negedge clk); #2; t++; end
    chk("reset test beats before reset", 64'(got), 64'd3);
    bus.rd_ctrl = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    burst_q.delete();
    #1;
    chk("midreset read", 64'(bus.read), 64'd0);
    chk("midreset fifo_wr", 64'(bus.fifo_wr), 64'd0);
    chk("midreset fifo_in", 64'(bus.fifo_in), 64'd0);
    chk("midreset rdy", 64'(bus.rd_ctrl_rdy), 64'd0);
    chk("midreset address", 64'(bus.address), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    t = 0;
    while (beat_q.size() > 0 && t < 100) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    salt = $urandom;
    run_pkt(32'd0, 32'd32, 1'b0);
    finish_pkt("after reset", 200, 0, 0);

    repeat (25) begin
      salt = $urandom;
      wait_pct = $urandom_range(0, 40);
      gap_pct = $urandom_range(0, 40);
      b = 32'(256 + 4 * $urandom_range(0, 1000));
      e = ($urandom_range(0, 7) == 0) ? b - 32'($urandom_range(1, 200)) : b + 32'($urandom_range(0, 150));
      run_pkt(b, e, $urandom_range(0, 3) == 0);
      finish_pkt("random", 3000, 1, $urandom_range(0, 1) == 1);
    end
    wait_pct = 0;
    gap_pct = 0;
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
